fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage that replaces the bare PC register of the single-cycle core. It holds the PC, drives the instruction-memory address, and captures fetched instructions into an IF/ID pipeline register with stall, flush and branch redirection. A trigger-gated run/halt state machine and a saturating cycle counter sit alongside the fetch logic. The block sits between instruction memory and the decode/control stage of the pipelined core.

## Interface
- WIDTH, 32, PC and instruction width in bits
- RESET_PC, 0, PC value after reset and after restart
- PC_STEP, 4, sequential PC increment
- CNT_W, 16, cycle counter width
- NOP, 32'h0000_0013, instruction inserted on flush (addi x0,x0,0)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- trigger  in  1  start (IDLE) / restart (HALTED) request, level-sampled
- stall  in  1  hold PC and IF/ID contents
- branch_taken  in  1  redirect request from execute stage
- branch_target  in  WIDTH  redirect address
- ex_pc  in  WIDTH  PC of the instruction issuing the redirect
- imem_addr  out  WIDTH  instruction memory address (= PC register)
- imem_rdata  in  WIDTH  instruction memory data, combinational read
- if_instr  out  WIDTH  IF/ID instruction
- if_pc  out  WIDTH  IF/ID PC
- if_pc_next  out  WIDTH  IF/ID PC + PC_STEP
- if_valid  out  1  IF/ID holds a real instruction
- running  out  1  state == RUN
- halted  out  1  state == HALTED
- misaligned  out  1  sticky: halt caused by misaligned target
- cycle_count  out  CNT_W  cycles spent in RUN, saturating

## Operation
- States: IDLE, RUN, HALTED (2-bit encoding, in package).
- IDLE: PC = RESET_PC, IF/ID = {NOP, 0, 0, valid 0}; trigger=1 -> RUN next cycle.
- RUN, priority per cycle: branch_taken > stall > normal.
  - normal: IF/ID <= {imem_rdata, PC, PC+PC_STEP, 1}; PC <= PC+PC_STEP.
  - stall: PC and IF/ID unchanged.
  - branch_taken, target[1:0]==0, target != ex_pc: PC <= target; IF/ID <= NOP, valid 0.
  - branch_taken, target == ex_pc (self-loop): -> HALTED; IF/ID flushed; PC <= target.
  - branch_taken, target[1:0] != 0: -> HALTED; misaligned <= 1; IF/ID flushed; PC unchanged.
- HALTED: PC, IF/ID frozen (flushed); branch_taken and stall ignored. trigger=1 -> RUN with PC <= RESET_PC, misaligned <= 0, cycle_count <= 0.
- cycle_count increments each clock in RUN (including stall cycles); saturates at all-ones; holds in IDLE/HALTED.
- PC arithmetic modulo 2^WIDTH: PC at all-ones minus PC_STEP+1 wraps to 0 without flag.

## Timing
- Reset (rst=0, async): state IDLE, PC=RESET_PC, if_instr=NOP, if_pc=0, if_pc_next=0, if_valid=0, misaligned=0, cycle_count=0, running=0, halted=0.
- imem_addr combinational from PC register, zero latency; IF/ID updates one cycle after address presented.
- trigger sampled at edge N -> running=1 after edge N; first valid IF/ID after edge N+1.
- Redirect at edge N -> if_valid=0 after N; target instruction in IF/ID after N+1 (one bubble).
- Reset asserted mid-RUN aborts immediately; no partial IF/ID update.
- running/halted are registered state decodes, no combinational path from inputs.

## Structure
- Package fetch_pkg: state enum, NOP default, PC_STEP default.
- One sub-module natural: sat_counter (parametrised width, enable, clear, saturate) for cycle_count.
- Next-PC mux and FSM in the top of fetch_unit; no other hierarchy.

## Test plan
- Reset then trigger=1 one cycle, imem_rdata=0x00500093 at addr 0 -> if_valid=1, if_instr=0x00500093, if_pc=0, if_pc_next=4 after second edge; imem_addr=4.
- Running, stall=1 for 3 cycles at PC=8 -> PC stays 8, IF/ID unchanged, cycle_count advances by 3.
- branch_taken=1, target=0x40, stall=1 same cycle -> PC=0x40, if_instr=0x13, if_valid=0; next cycle instruction from 0x40 valid.
- branch_taken=1, target=ex_pc=0x1C -> halted=1, running=0; further branches/stalls ignored; trigger -> PC=RESET_PC, cycle_count=0.
- branch_taken=1, target=0x22 -> halted=1, misaligned=1, PC unchanged; trigger clears misaligned.
- CNT_W=4, run 20 cycles -> cycle_count saturates at 15; rst=0 mid-run -> all outputs at reset values immediately, before next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int unsigned DEFAULT_PC_STEP = 4;

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus, redirect inputs and IF/ID outputs of the fetch stage.
interface fetch_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] if_instr;
    logic [WIDTH-1:0] if_pc;
    logic [WIDTH-1:0] if_pc_next;
    logic             if_valid;

    modport master (
        output imem_addr, if_instr, if_pc, if_pc_next, if_valid,
        input  imem_rdata, stall, branch_taken, branch_target, ex_pc
    );

    modport slave (
        input  imem_addr, if_instr, if_pc, if_pc_next, if_valid,
        output imem_rdata, stall, branch_taken, branch_target, ex_pc
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, IF/ID register with stall/flush/redirect, run/halt FSM
// and a saturating count of cycles spent running.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      PC_STEP  = DEFAULT_PC_STEP,
    parameter int               CNT_W    = 16,
    parameter logic [WIDTH-1:0] NOP      = WIDTH'(NOP_INSTR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    fetch_if.master          bus,
    output logic             running,
    output logic             halted,
    output logic             misaligned,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] ifpc_q, ifpc_d;
    logic [WIDTH-1:0] ifpcn_q, ifpcn_d;
    logic             valid_q, valid_d;
    logic             mis_q, mis_d;
    logic             cnt_clear;
    logic [WIDTH-1:0] pc_plus;

    assign pc_plus = pc_q + STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            ifpc_q  <= '0;
            ifpcn_q <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpcn_q <= ifpcn_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    // Redirect beats stall beats sequential fetch; a halting redirect also flushes IF/ID.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifpc_d    = ifpc_q;
        ifpcn_d   = ifpcn_q;
        valid_d   = valid_q;
        mis_d     = mis_q;
        cnt_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                pc_d    = RESET_PC;
                instr_d = NOP;
                ifpc_d  = '0;
                ifpcn_d = '0;
                valid_d = 1'b0;
                if (trigger) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.branch_taken) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    if (!is_aligned(bus.branch_target[1:0])) begin
                        state_d = ST_HALTED;
                        mis_d   = 1'b1;
                    end else begin
                        pc_d = bus.branch_target;
                        if (bus.branch_target == bus.ex_pc) begin
                            state_d = ST_HALTED;
                        end
                    end
                end else if (!bus.stall) begin
                    instr_d = bus.imem_rdata;
                    ifpc_d  = pc_q;
                    ifpcn_d = pc_plus;
                    valid_d = 1'b1;
                    pc_d    = pc_plus;
                end
            end
            ST_HALTED: begin
                if (trigger) begin
                    state_d   = ST_RUN;
                    pc_d      = RESET_PC;
                    mis_d     = 1'b0;
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_counter (
        .clk   (clk),
        .rst   (rst),
        .enable(state_q == ST_RUN),
        .clear (cnt_clear),
        .count (cycle_count)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.if_instr   = instr_q;
    assign bus.if_pc      = ifpc_q;
    assign bus.if_pc_next = ifpcn_q;
    assign bus.if_valid   = valid_q;
    assign running        = (state_q == ST_RUN);
    assign halted         = (state_q == ST_HALTED);
    assign misaligned     = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reference model plus an IF/ID scoreboard queue.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcNext;
    } ifidT;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic        running;
    logic        halted;
    logic        misaligned;
    logic [3:0]  cycleCount;

    int          checks = 0;
    int          errors = 0;

    int          mState;
    logic [31:0] mPc;
    logic        mValid;
    logic        mMis;
    logic [3:0]  mCnt;
    ifidT        sbQ[$];
    ifidT        cur;

    fetch_if #(.WIDTH(32)) bus ();

    fetch_unit #(
        .WIDTH   (32),
        .RESET_PC(32'h0),
        .PC_STEP (4),
        .CNT_W   (4),
        .NOP     (32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .bus        (bus),
        .running    (running),
        .halted     (halted),
        .misaligned (misaligned),
        .cycle_count(cycleCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memModel(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0050_0093;
        return {addr[23:0], 8'h13};
    endfunction

    always_comb bus.imem_rdata = memModel(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mState = 0;
        mPc    = 32'h0;
        mValid = 1'b0;
        mMis   = 1'b0;
        mCnt   = 4'h0;
        sbQ.delete();
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_imem_addr"}, bus.imem_addr, 32'h0);
        check({tag, "_if_instr"}, bus.if_instr, 32'h13);
        check({tag, "_if_pc"}, bus.if_pc, 32'h0);
        check({tag, "_if_pc_next"}, bus.if_pc_next, 32'h0);
        check({tag, "_if_valid"}, 32'(bus.if_valid), 32'h0);
        check({tag, "_running"}, 32'(running), 32'h0);
        check({tag, "_halted"}, 32'(halted), 32'h0);
        check({tag, "_misaligned"}, 32'(misaligned), 32'h0);
        check({tag, "_cycle_count"}, 32'(cycleCount), 32'h0);
    endtask

    task automatic checkOutput();
        if (sbQ.size() > 0) cur = sbQ.pop_front();
        check("imem_addr", bus.imem_addr, mPc);
        check("running", 32'(running), 32'(mState == 1));
        check("halted", 32'(halted), 32'(mState == 2));
        check("misaligned", 32'(misaligned), 32'(mMis));
        check("cycle_count", 32'(cycleCount), 32'(mCnt));
        check("if_valid", 32'(bus.if_valid), 32'(mValid));
        if (mValid) begin
            check("if_instr", bus.if_instr, cur.instr);
            check("if_pc", bus.if_pc, cur.pc);
            check("if_pc_next", bus.if_pc_next, cur.pcNext);
        end else begin
            check("if_instr_nop", bus.if_instr, 32'h13);
        end
    endtask

    task automatic applyStimulus(input logic trig, input logic stl, input logic br,
                                 input logic [31:0] tgt, input logic [31:0] exPc);
        trigger           = trig;
        bus.stall         = stl;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.ex_pc         = exPc;
        case (mState)
            0: begin
                mPc    = 32'h0;
                mValid = 1'b0;
                if (trig) mState = 1;
            end
            1: begin
                if (mCnt != 4'hF) mCnt = mCnt + 4'h1;
                if (br) begin
                    mValid = 1'b0;
                    if (tgt[1:0] != 2'b00) begin
                        mState = 2;
                        mMis   = 1'b1;
                    end else begin
                        if (tgt == exPc) mState = 2;
                        mPc = tgt;
                    end
                end else if (!stl) begin
                    sbQ.push_back('{memModel(mPc), mPc, mPc + 32'd4});
                    mValid = 1'b1;
                    mPc    = mPc + 32'd4;
                end
            end
            default: begin
                if (trig) begin
                    mState = 1;
                    mPc    = 32'h0;
                    mMis   = 1'b0;
                    mCnt   = 4'h0;
                end
            end
        endcase
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst               = 1'b0;
        trigger           = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.ex_pc         = 32'h0;
        resetModel();
        cur = '{32'h13, 32'h0, 32'h0};
        repeat (2) @(posedge clk);
        #1;
        checkReset("por");
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] start and first fetch");
        applyStimulus(1, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);

        $display("[TB] stall at PC 8");
        repeat (3) applyStimulus(0, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);

        $display("[TB] redirect beats stall");
        applyStimulus(0, 1, 1, 32'h40, 32'h8);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);

        $display("[TB] self-loop halt and restart");
        applyStimulus(0, 0, 1, 32'h1C, 32'h1C);
        applyStimulus(0, 1, 1, 32'h80, 32'h4);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);

        $display("[TB] misaligned target");
        applyStimulus(0, 0, 1, 32'h22, 32'h10);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 32'h0);

        $display("[TB] counter saturation");
        repeat (20) applyStimulus(0, 0, 0, 32'h0, 32'h0);
        check("cnt_saturated", 32'(cycleCount), 32'hF);

        $display("[TB] PC wrap");
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 32'h10);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);

        $display("[TB] asynchronous reset mid-run");
        #2;
        rst = 1'b0;
        #1;
        checkReset("midrun");
        resetModel();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
